// File: rtl/serial_comp.sv
// serial_comp: wide unsigned magnitude comparator. It walks the operands one
// nibble per cycle through a single comp4, starting at the most significant
// nibble, and stops at the first nibble pair that differs.
// WIDTH must be a multiple of 4 and at least 4.

// comp4: combinational 4-bit unsigned magnitude compare
module comp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  // Exactly one of eq/gt/lt is asserted for any input pair
  always_comb begin
    eq = (a == b);
    gt = (a > b);
    lt = (a < b);
  end

endmodule

module serial_comp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NIBBLES = WIDTH / 4;
  // A single-nibble build still needs a 1-bit index register
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [IW-1:0]    r_idx;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic             w_load;
  logic             w_dec;
  logic             w_finish;
  logic [IW+1:0]    w_bitIdx;
  logic [3:0]       w_nibA;
  logic [3:0]       w_nibB;
  logic             w_cEq;
  logic             w_cGt;
  logic             w_cLt;

  // Select the nibble pair addressed by the current index
  always_comb begin
    w_bitIdx = {r_idx, 2'b00};
    w_nibA   = r_opA[w_bitIdx +: 4];
    w_nibB   = r_opB[w_bitIdx +: 4];
  end

  comp4 u_comp4 (
    .a  (w_nibA),
    .b  (w_nibB),
    .eq (w_cEq),
    .gt (w_cGt),
    .lt (w_cLt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and datapath control strobes
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_nextState = CMP;
        end
      end
      CMP: begin
        if (!w_cEq || (r_idx == '0)) begin
          w_finish    = 1'b1;
          w_nextState = DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      DONE: begin
        // A start arriving during the done cycle is accepted straight away
        if (start) begin
          w_load      = 1'b1;
          w_nextState = CMP;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture, nibble index and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opA <= '0;
      r_opB <= '0;
      r_idx <= '0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      if (w_load) begin
        r_opA <= a;
        r_opB <= b;
        r_idx <= IW'(NIBBLES - 1);
        r_eq  <= 1'b0;
        r_gt  <= 1'b0;
        r_lt  <= 1'b0;
      end else if (w_dec) begin
        r_idx <= r_idx - IW'(1);
      end
      // On the finishing cycle comp4 eq can only be 1 when idx is 0,
      // so its flags are the final answer either way
      if (w_finish) begin
        r_eq <= w_cEq;
        r_gt <= w_cGt;
        r_lt <= w_cLt;
      end
    end
  end

  // Status outputs decode straight from the registered state
  always_comb begin
    busy = (r_state == CMP);
    done = (r_state == DONE);
    eq   = r_eq;
    gt   = r_gt;
    lt   = r_lt;
  end

endmodule

// File: tb/tb_serial_comp.sv
// Testbench for serial_comp (WIDTH=16): table of operand pairs with expected
// result and latency, fed through a scoreboard queue, plus hand-written
// sequences for reset, operand disturbance and back-to-back starts.
module tb_serial_comp;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       res;    // {eq,gt,lt}
    int               edges;  // rising edges from start edge to done
    string            name;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  int   testsRun;
  int   testsFailed;
  vec_t sbQueue[$];
  vec_t vecs[7];
  vec_t lastVec;

  serial_comp #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  // Drive operands and start (call at a negedge) and record the expectation
  task automatic applyStimulus(input vec_t v);
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    sbQueue.push_back(v);
  endtask

  // Step from the start edge until done, then score against the queue head
  task automatic runToDone(input bit disturb, output vec_t v);
    int  edges;
    int  busyCnt;
    bit  seen;
    edges   = 0;
    busyCnt = 0;
    seen    = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        start = 1'b0;
        checkOutput("resultsClearedOnStart", {29'd0, eq, gt, lt}, 32'd0);
      end
      if (disturb && edges == 2) begin
        a     = 16'hFFFF;
        start = 1'b1;
      end
      if (disturb && edges == 3) begin
        start = 1'b0;
      end
      if (busy) busyCnt++;
      if (done) seen = 1'b1;
    end
    v = sbQueue.pop_front();
    if (!seen) begin
      checkOutput({v.name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({v.name, "_result"}, {29'd0, eq, gt, lt}, {29'd0, v.res});
      checkOutput({v.name, "_latency"}, edges, v.edges);
      checkOutput({v.name, "_busyCycles"}, busyCnt, v.edges - 1);
      checkOutput({v.name, "_oneHot"}, 32'(eq) + 32'(gt) + 32'(lt), 32'd1);
    end
  endtask

  // Done must be a single cycle and the result must hold afterwards
  task automatic checkAfterDone(input vec_t v);
    @(posedge clk);
    @(negedge clk);
    checkOutput({v.name, "_donePulse"}, {31'd0, done}, 32'd0);
    checkOutput({v.name, "_idleAfter"}, {31'd0, busy}, 32'd0);
    checkOutput({v.name, "_resultHeld"}, {29'd0, eq, gt, lt}, {29'd0, v.res});
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // {a, b, {eq,gt,lt}, edges, name}
    vecs[0] = '{16'h8000, 16'h7FFF, 3'b010, 2, "msbDiffers"};
    vecs[1] = '{16'h1234, 16'h1234, 3'b100, 5, "equal1234"};
    vecs[2] = '{16'h0000, 16'hFFFF, 3'b001, 2, "zeroVsOnes"};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 3'b100, 5, "equalOnes"};
    vecs[4] = '{16'hABCD, 16'hAB0D, 3'b010, 4, "nibble1Gt"};
    vecs[5] = '{16'h1200, 16'h1300, 3'b001, 3, "nibble2Lt"};
    vecs[6] = '{16'h0000, 16'h0000, 3'b100, 5, "equalZero"};

    // Reset state while rst is held
    repeat (2) @(negedge clk);
    checkOutput("resetState", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      runToDone(1'b0, lastVec);
      checkAfterDone(lastVec);
    end

    // Operand change and start pulse while busy are ignored
    applyStimulus('{16'h1233, 16'h1234, 3'b001, 5, "lsbDiffersDisturbed"});
    runToDone(1'b1, lastVec);
    checkAfterDone(lastVec);

    // Back-to-back: start held through the done cycle
    applyStimulus('{16'hFFFF, 16'h0000, 3'b010, 2, "firstOfPair"});
    runToDone(1'b0, lastVec);
    applyStimulus('{16'h0001, 16'h0002, 3'b001, 5, "backToBack"});
    runToDone(1'b0, lastVec);
    checkAfterDone(lastVec);

    // Reset mid-operation, asserted away from any clock edge
    a     = 16'hABCD;
    b     = 16'hABCD;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncResetMidCmp", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("noDoneDuringReset", {30'd0, busy, done}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("noDoneAfterReset", {31'd0, done}, 32'd0);
    end

    applyStimulus('{16'h00F0, 16'h00E0, 3'b010, 4, "afterReset"});
    runToDone(1'b0, lastVec);
    checkAfterDone(lastVec);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
